alu_arbiter: RTL and testbench

//  Shares the single combinational 16-bit ALU between two requesters (req0, req1) with round-robin arbitration.

---
 rtl/alu_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin front end for the shared combinational ALU: two requesters, one
// registered issue slot, a valid/ready response channel and the architectural flags.
module alu_arbiter #(
  parameter int WIDTH = 16,
  parameter int OPW   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_opcode,
  input  logic [WIDTH-1:0] req0_term1,
  input  logic [WIDTH-1:0] req0_term2,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_opcode,
  input  logic [WIDTH-1:0] req1_term1,
  input  logic [WIDTH-1:0] req1_term2,
  output logic [OPW-1:0]   alu_opcode,
  output logic [WIDTH-1:0] alu_term1,
  output logic [WIDTH-1:0] alu_term2,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_negative,
  input  logic             alu_overflow,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_wb,
  output logic             rsp_err,
  output logic [3:0]       flags_q
);

  // Opcode encoding shared with the ALU.
  localparam logic [OPW-1:0] OP_NOP = OPW'(0),  OP_ADD = OPW'(1),  OP_SUB = OPW'(2);
  localparam logic [OPW-1:0] OP_MUL = OPW'(3),  OP_DIV = OPW'(4),  OP_MOD = OPW'(5);
  localparam logic [OPW-1:0] OP_CMP = OPW'(6),  OP_INC = OPW'(7),  OP_DEC = OPW'(8);
  localparam logic [OPW-1:0] OP_LSR = OPW'(9),  OP_LSL = OPW'(10), OP_RSR = OPW'(11);
  localparam logic [OPW-1:0] OP_RSL = OPW'(12), OP_MOV = OPW'(13), OP_AND = OPW'(14);
  localparam logic [OPW-1:0] OP_OR  = OPW'(15), OP_XOR = OPW'(16), OP_TST = OPW'(17);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] t1_q, t1_d, t2_q, t2_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic             wb_q, wb_d, err_q, err_d, kill_q, kill_d;
  logic             fall_q, fall_d, fz_q, fz_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_wb_q, rsp_wb_d, rsp_err_q, rsp_err_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d, flags_d;

  logic             can_accept, last_id, gnt;
  logic [OPW-1:0]   sel_op;
  logic [WIDTH-1:0] sel_t2;
  logic             dec_wb, dec_err, dec_illegal, dec_nop, dec_fall, dec_fz;

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    id_d         = id_q;
    t1_d         = t1_q;
    t2_d         = t2_q;
    alu_op_d     = alu_op_q;
    wb_d         = wb_q;
    err_d        = err_q;
    kill_d       = kill_q;
    fall_d       = fall_q;
    fz_d         = fz_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_wb_d     = rsp_wb_q;
    rsp_err_d    = rsp_err_q;
    rsp_flags_d  = rsp_flags_q;
    flags_d      = flags_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    dec_wb       = 1'b0;
    dec_err      = 1'b0;
    dec_illegal  = 1'b0;
    dec_nop      = 1'b0;
    dec_fall     = 1'b0;
    dec_fz       = 1'b0;

    // A back-to-back grant in RESP must already see the retiring owner as "last".
    can_accept = (state_q == IDLE) || (state_q == RESP && rsp_ready);
    last_id    = (state_q == RESP) ? id_q : rr_q;
    gnt        = (req0_valid && req1_valid) ? ~last_id : req1_valid;
    sel_op     = gnt ? req1_opcode : req0_opcode;
    sel_t2     = gnt ? req1_term2 : req0_term2;

    case (sel_op)
      OP_ADD, OP_SUB, OP_MUL, OP_INC, OP_DEC: begin
        dec_wb   = 1'b1;
        dec_fall = 1'b1;
      end
      OP_DIV, OP_MOD: begin
        if (sel_t2 == '0) begin
          dec_err = 1'b1;
        end else begin
          dec_wb   = 1'b1;
          dec_fall = 1'b1;
        end
      end
      OP_CMP: dec_fall = 1'b1;
      OP_LSR, OP_LSL, OP_RSR, OP_RSL, OP_MOV, OP_AND, OP_OR, OP_XOR: begin
        dec_wb = 1'b1;
        dec_fz = 1'b1;
      end
      OP_TST: dec_fz = 1'b1;
      OP_NOP: dec_nop = 1'b1;
      default: begin
        dec_err     = 1'b1;
        dec_illegal = 1'b1;
      end
    endcase

    case (state_q)
      EXEC: begin
        rsp_valid_d  = 1'b1;
        rsp_id_d     = id_q;
        rsp_result_d = kill_q ? '0 : alu_out;
        rsp_wb_d     = wb_q;
        rsp_err_d    = err_q;
        rsp_flags_d  = {alu_zero, alu_negative, alu_overflow, alu_carry};
        alu_op_d     = OP_NOP;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_d        = id_q;
          state_d     = IDLE;
          if (fall_q) begin
            flags_d = rsp_flags_q;
          end else if (fz_q) begin
            flags_d[3] = rsp_flags_q[3];
          end
        end
      end
      default: ;
    endcase

    if (can_accept && (req0_valid || req1_valid)) begin
      req0_ready = ~gnt;
      req1_ready = gnt;
      id_d       = gnt;
      t1_d       = gnt ? req1_term1 : req0_term1;
      t2_d       = sel_t2;
      alu_op_d   = dec_illegal ? OP_NOP : sel_op;
      wb_d       = dec_wb;
      err_d      = dec_err;
      kill_d     = dec_err || dec_nop;
      fall_d     = dec_fall;
      fz_d       = dec_fz;
      state_d    = EXEC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_q         <= 1'b1;
      id_q         <= 1'b0;
      t1_q         <= '0;
      t2_q         <= '0;
      alu_op_q     <= '0;
      wb_q         <= 1'b0;
      err_q        <= 1'b0;
      kill_q       <= 1'b0;
      fall_q       <= 1'b0;
      fz_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_wb_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_flags_q  <= '0;
      flags_q      <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      id_q         <= id_d;
      t1_q         <= t1_d;
      t2_q         <= t2_d;
      alu_op_q     <= alu_op_d;
      wb_q         <= wb_d;
      err_q        <= err_d;
      kill_q       <= kill_d;
      fall_q       <= fall_d;
      fz_q         <= fz_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_wb_q     <= rsp_wb_d;
      rsp_err_q    <= rsp_err_d;
      rsp_flags_q  <= rsp_flags_d;
      flags_q      <= flags_d;
    end
  end

  assign alu_opcode = alu_op_q;
  assign alu_term1  = t1_q;
  assign alu_term2  = t2_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_wb     = rsp_wb_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, scoreboard of expected responses and flags,
// directed steps for latency, arbitration, flag classes, errors, backpressure and reset.
module tb_alu_arbiter;

  localparam logic [5:0] O_NOP = 6'd0,  O_ADD = 6'd1,  O_SUB = 6'd2,  O_DIV = 6'd4;
  localparam logic [5:0] O_CMP = 6'd6,  O_INC = 6'd7,  O_MOV = 6'd13, O_AND = 6'd14;
  localparam logic [5:0] O_XOR = 6'd16, O_TST = 6'd17, O_BAD = 6'h3F;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [5:0]  req0_opcode, req1_opcode, alu_opcode;
  logic [15:0] req0_term1, req0_term2, req1_term1, req1_term2;
  logic [15:0] alu_term1, alu_term2, alu_out, rsp_result;
  logic        alu_zero, alu_negative, alu_overflow, alu_carry;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_wb, rsp_err;
  logic [3:0]  flags_q;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        id;
    logic [15:0] res;
    logic        wb;
    logic        err;
    logic [1:0]  fm;
    logic [3:0]  fl;
  } exp_t;

  exp_t        sb[$];
  bit          grants[$];
  int          gcyc[$];
  int          cyc = 0;
  bit          mon_en = 1'b0;
  bit          hold = 1'b0;
  logic [18:0] snap;
  logic [3:0]  exp_flags = '0;
  exp_t        e;

  always #5 clk = ~clk;

  // Returns {Z,N,V,C,result}; C is borrow for SUB/CMP.
  function automatic logic [19:0] alu_model(logic [5:0] op, logic [15:0] a, logic [15:0] b);
    logic [16:0] w;
    logic [31:0] m;
    logic [15:0] r;
    logic        c, v;
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      6'd1: begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16];
                  v = (a[15] == b[15]) && (r[15] != a[15]); end
      6'd2, 6'd6: begin r = a - b; c = (a < b); v = (a[15] != b[15]) && (r[15] != a[15]); end
      6'd3: begin m = 32'(a) * 32'(b); r = m[15:0]; c = |m[31:16]; v = c; end
      6'd4: r = (b == 0) ? 16'hFFFF : a / b;
      6'd5: r = (b == 0) ? a : a % b;
      6'd7: begin r = a + 16'd1; v = (a == 16'h7FFF); c = (a == 16'hFFFF); end
      6'd8: begin r = a - 16'd1; v = (a == 16'h8000); c = (a == 16'h0000); end
      6'd9:  begin r = a >> 1; c = a[0]; end
      6'd10: begin r = a << 1; c = a[15]; end
      6'd11: r = {a[0], a[15:1]};
      6'd12: r = {a[14:0], a[15]};
      6'd13: r = a;
      6'd14, 6'd17: r = a & b;
      6'd15: r = a | b;
      6'd16: r = a ^ b;
      default: r = '0;
    endcase
    return {(r == 16'h0), r[15], v, c, r};
  endfunction

  function automatic exp_t exp_of(logic id, logic [5:0] op, logic [15:0] a, logic [15:0] b);
    exp_t        x;
    logic [19:0] f;
    f = alu_model(op, a, b);
    x.id = id; x.res = f[15:0]; x.fl = f[19:16]; x.wb = 1'b0; x.err = 1'b0; x.fm = 2'd0;
    case (op)
      6'd1, 6'd2, 6'd3, 6'd7, 6'd8: begin x.wb = 1'b1; x.fm = 2'd2; end
      6'd4, 6'd5: if (b == 0) begin x.err = 1'b1; x.res = '0; end
                  else begin x.wb = 1'b1; x.fm = 2'd2; end
      6'd6: x.fm = 2'd2;
      6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16: begin x.wb = 1'b1; x.fm = 2'd1; end
      6'd17: x.fm = 2'd1;
      6'd0: x.res = '0;
      default: begin x.err = 1'b1; x.res = '0; end
    endcase
    return x;
  endfunction

  assign {alu_zero, alu_negative, alu_overflow, alu_carry, alu_out} =
    alu_model(alu_opcode, alu_term1, alu_term2);

  alu_arbiter #(.WIDTH(16), .OPW(6)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_term1(req0_term1), .req0_term2(req0_term2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_term1(req1_term1), .req1_term2(req1_term2),
    .alu_opcode(alu_opcode), .alu_term1(alu_term1), .alu_term2(alu_term2),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_negative(alu_negative),
    .alu_overflow(alu_overflow), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_wb(rsp_wb), .rsp_err(rsp_err), .flags_q(flags_q)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on request handshake, pop on response handshake, track flags.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      sb.delete();
      exp_flags = '0;
      hold = 1'b0;
    end else if (mon_en) begin
      chk("flags", 32'(flags_q), 32'(exp_flags));
      chk("ready_excl", 32'(req0_ready & req1_ready), 0);
      if (hold) begin
        chk("rsp_hold_valid", 32'(rsp_valid), 1);
        chk("rsp_stable", 32'({rsp_id, rsp_result, rsp_wb, rsp_err}), 32'(snap));
      end
      if (rsp_valid && rsp_ready) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_result", 32'(rsp_result), 32'(e.res));
          chk("rsp_wb", 32'(rsp_wb), 32'(e.wb));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          if (e.fm == 2'd2) exp_flags = e.fl;
          else if (e.fm == 2'd1) exp_flags[3] = e.fl[3];
        end
      end
      hold = rsp_valid && !rsp_ready;
      snap = {rsp_id, rsp_result, rsp_wb, rsp_err};
      if (req0_valid && req0_ready) begin
        sb.push_back(exp_of(1'b0, req0_opcode, req0_term1, req0_term2));
        grants.push_back(1'b0); gcyc.push_back(cyc);
      end
      if (req1_valid && req1_ready) begin
        sb.push_back(exp_of(1'b1, req1_opcode, req1_term1, req1_term2));
        grants.push_back(1'b1); gcyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit p, input logic v, input logic [5:0] op,
                       input logic [15:0] a, input logic [15:0] b);
    if (p) begin req1_valid = v; req1_opcode = op; req1_term1 = a; req1_term2 = b; end
    else   begin req0_valid = v; req0_opcode = op; req0_term1 = a; req0_term2 = b; end
  endtask

  task automatic issue(input bit p, input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    drive(p, 1'b1, op, a, b);
    #1;
    while (!(p ? req1_ready : req0_ready) && n < 20) begin tick(); n++; end
    chk("issue_ready", 32'(p ? req1_ready : req0_ready), 1);
    tick();
    drive(p, 1'b0, op, a, b);
  endtask

  task automatic wait_rsp(output logic [15:0] r, output logic er, output logic w);
    int n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    chk("rsp_arrive", 32'(rsp_valid), 1);
    r = rsp_result; er = rsp_err; w = rsp_wb;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    logic        er, w;
    reset = 1'b1; rsp_ready = 1'b1;
    drive(1'b0, 1'b0, O_NOP, '0, '0);
    drive(1'b1, 1'b0, O_NOP, '0, '0);
    tick(); tick();
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_alu_opcode", 32'(alu_opcode), 0);
    chk("rst_alu_term1", 32'(alu_term1), 0);
    chk("rst_flags", 32'(flags_q), 0);
    chk("rst_rsp_result", 32'(rsp_result), 0);
    chk("rst_ready", 32'(req0_ready | req1_ready), 0);
    reset = 1'b0; mon_en = 1'b1;

    // Latency: valid driven after edge N, accepted at N+1, response after N+2.
    tick();
    drive(1'b0, 1'b1, O_ADD, 16'h0F0F, 16'hF0F0);
    #1;
    chk("t1_req0_ready", 32'(req0_ready), 1);
    chk("t1_req1_ready", 32'(req1_ready), 0);
    tick();
    drive(1'b0, 1'b0, O_ADD, 16'h0F0F, 16'hF0F0);
    chk("t1_n1_rsp_valid", 32'(rsp_valid), 0);
    chk("t1_exec_op", 32'(alu_opcode), 32'(O_ADD));
    chk("t1_exec_t1", 32'(alu_term1), 'h0F0F);
    chk("t1_exec_t2", 32'(alu_term2), 'hF0F0);
    tick();
    chk("t1_n2_rsp_valid", 32'(rsp_valid), 1);
    chk("t1_result", 32'(rsp_result), 'hFFFF);
    chk("t1_id", 32'(rsp_id), 0);
    chk("t1_wb", 32'(rsp_wb), 1);
    chk("t1_nop_outside_exec", 32'(alu_opcode), 0);
    chk("t1_term_hold", 32'(alu_term1), 'h0F0F);
    tick();
    chk("t1_flags", 32'(flags_q), 'b0100);
    chk("t1_rsp_cleared", 32'(rsp_valid), 0);

    // Round robin with both requesters continuously valid.
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    grants.delete(); gcyc.delete();
    drive(1'b0, 1'b1, O_SUB, 16'h0010, 16'h0003);
    drive(1'b1, 1'b1, O_AND, 16'h00F0, 16'h0F0F);
    repeat (8) tick();
    drive(1'b0, 1'b0, O_SUB, 16'h0010, 16'h0003);
    drive(1'b1, 1'b0, O_AND, 16'h00F0, 16'h0F0F);
    repeat (3) tick();
    chk("t2_ngrants", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
      chk("t2_grant_id", 32'(grants[i]), i % 2);
      if (i > 0) chk("t2_grant_spacing", gcyc[i] - gcyc[i-1], 2);
    end
    chk("t2_flags", 32'(flags_q), 'b1000);

    // Flag classes.
    issue(1'b0, O_SUB, 16'h0000, 16'h0001); wait_rsp(r, er, w);
    chk("t3_sub_flags", 32'(flags_q), 'b0101);
    issue(1'b0, O_CMP, 16'h0055, 16'h0055); wait_rsp(r, er, w);
    chk("t3_cmp_wb", 32'(w), 0);
    chk("t3_cmp_err", 32'(er), 0);
    chk("t3_cmp_flags", 32'(flags_q), 'b1000);
    issue(1'b0, O_SUB, 16'h0000, 16'h0001); wait_rsp(r, er, w);
    issue(1'b1, O_TST, 16'h00F0, 16'h000F); wait_rsp(r, er, w);
    chk("t3_test_flags", 32'(flags_q), 'b1101);
    issue(1'b0, O_XOR, 16'h0055, 16'h0003); wait_rsp(r, er, w);
    chk("t3_xor_result", 32'(r), 'h0056);
    chk("t3_xor_flags", 32'(flags_q), 'b0101);

    // Errors and NOP.
    issue(1'b1, O_DIV, 16'h0055, 16'h0000);
    chk("t4_div_sequenced", 32'(alu_opcode), 32'(O_DIV));
    wait_rsp(r, er, w);
    chk("t4_div_err", 32'(er), 1);
    chk("t4_div_wb", 32'(w), 0);
    chk("t4_div_result", 32'(r), 0);
    chk("t4_div_flags", 32'(flags_q), 'b0101);
    issue(1'b0, O_BAD, 16'h1234, 16'h5678);
    chk("t4_bad_alu_nop", 32'(alu_opcode), 0);
    wait_rsp(r, er, w);
    chk("t4_bad_err", 32'(er), 1);
    chk("t4_bad_result", 32'(r), 0);
    chk("t4_bad_flags", 32'(flags_q), 'b0101);
    issue(1'b1, O_NOP, 16'h1111, 16'h2222); wait_rsp(r, er, w);
    chk("t4_nop_err", 32'(er), 0);
    chk("t4_nop_result", 32'(r), 0);

    // Backpressure with a pending request, then back-to-back accept on release.
    rsp_ready = 1'b0;
    issue(1'b0, O_ADD, 16'h0001, 16'h0001); wait_rsp(r, er, w);
    drive(1'b1, 1'b1, O_INC, 16'h7FFF, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_req1_ready", 32'(req1_ready), 0);
      chk("t5_rsp_valid", 32'(rsp_valid), 1);
      chk("t5_rsp_result", 32'(rsp_result), 'h0002);
      chk("t5_flags", 32'(flags_q), 'b0101);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("t5_release_ready", 32'(req1_ready), 1);
    tick();
    drive(1'b1, 1'b0, O_INC, 16'h7FFF, 16'h0000);
    chk("t5_flags_updated", 32'(flags_q), 'b0000);
    chk("t5_b2b_exec", 32'(alu_opcode), 32'(O_INC));
    wait_rsp(r, er, w);
    chk("t5_inc_result", 32'(r), 'h8000);
    chk("t5_inc_flags", 32'(flags_q), 'b0110);

    // Reset during EXEC drops the operation.
    issue(1'b0, O_ADD, 16'h0002, 16'h0003);
    chk("t6_in_exec", 32'(alu_opcode), 32'(O_ADD));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rsp_valid", 32'(rsp_valid), 0);
    chk("t6_flags", 32'(flags_q), 0);
    chk("t6_alu_opcode", 32'(alu_opcode), 0);
    repeat (4) begin
      tick();
      chk("t6_no_stale_rsp", 32'(rsp_valid), 0);
    end
    issue(1'b1, O_MOV, 16'h1234, 16'h0000); wait_rsp(r, er, w);
    chk("t6_after_reset_result", 32'(r), 'h1234);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
